lock_chamber_ctrl: RTL
======================

Name: lock_chamber_ctrl

Overview:
- Parametrised single-chamber canal-lock sequencer; next generation of the occupancy/water/gate control trio, merged into one FSM.
- Tracks water level internally, drives fill/drain valves and both gates, and latches boat requests from either side.
- Adds request queuing, empty-chamber turnaround, timed gate travel, and a hold (pause) input.
- Sits under the lab top level; outputs feed LEDs/HEX display logic.

Parameters:
- LEVEL_W, 6, width of water level.
- LOW_LEVEL, 8, level matching the downstream (lower) side.
- HIGH_LEVEL, 40, level matching the upstream (upper) side; must be greater than LOW_LEVEL and less than 2^LEVEL_W.
- FILL_STEP, 4, level increase per tick while filling.
- DRAIN_STEP, 4, level decrease per tick while draining.
- TICK_DIV, 5, clocks per level tick; must be at least 1.
- GATE_CYCLES, 3, clocks for one gate travel; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; the one clock domain is clk.
- arrive_low  in  1  pulse: boat waiting at the lower side.
- arrive_high  in  1  pulse: boat waiting at the upper side.
- boat_in  in  1  pulse: boat fully inside the chamber.
- boat_out  in  1  pulse: boat fully left the chamber.
- hold  in  1  level: freeze timers, tick and level; valves forced off.
- lower_gate_open  out  1  lower gate open.
- upper_gate_open  out  1  upper gate open.
- gate_moving  out  1  a gate is travelling.
- fill_valve  out  1  fill valve on.
- drain_valve  out  1  drain valve on.
- occupied  out  1  boat in chamber.
- water_level  out  LEVEL_W  current level.
- pend_low  out  1  latched lower-side request.
- pend_high  out  1  latched upper-side request.
- state_code  out  4  FSM state, encoded as listed below.

Behaviour:
- Reset values: state LOW_IDLE, water_level=LOW_LEVEL, lower_gate_open=1, all other outputs 0, internal timers 0.
- State encodings: LOW_IDLE=0, LOW_ENTER=1, HIGH_IDLE=2, HIGH_ENTER=3, CLOSE=4, FILL=5, DRAIN=6, OPEN=7, EXIT=8.
- Requests:
  - A pulse on arrive_low/arrive_high sets pend_low/pend_high on the next edge. It stays set until served.
  - A request arriving while its flag is already set is absorbed.
- LOW_IDLE:
  - If pend_low: go to LOW_ENTER.
  - Else if pend_high: dir_up=1, go to CLOSE (empty turnaround).
  - Both pending: the lower side wins.
- HIGH_IDLE: mirror of LOW_IDLE; the upper side wins.
- LOW_ENTER: on boat_in, set occupied=1, clear pend_low, set dir_up=1, go to CLOSE. The HIGH_ENTER mirror clears pend_high and sets dir_up=0.
- CLOSE:
  - On entry the open gate's output drops to 0 (same edge as the state change).
  - gate_moving=1 for exactly GATE_CYCLES cycles.
  - Then go to FILL if dir_up, else DRAIN.
- FILL:
  - fill_valve=1 while hold=0.
  - Tick counter is cleared on entry; every TICK_DIV unheld cycles, level += FILL_STEP, saturating at HIGH_LEVEL.
  - On the cycle after level==HIGH_LEVEL, go to OPEN.
- DRAIN: mirror of FILL; drain_valve=1, level -= DRAIN_STEP, floor at LOW_LEVEL.
- OPEN:
  - gate_moving=1 for GATE_CYCLES cycles.
  - The destination gate output asserts on the edge leaving OPEN.
  - If occupied: go to EXIT. Else: go to HIGH_IDLE if dir_up, else LOW_IDLE.
- EXIT: on boat_out, clear occupied and go to the idle state of the open side.
- Invariants, checked by assertion:
  - Never both gates open.
  - No valve on unless both gates are closed.
  - fill_valve and drain_valve are mutually exclusive.
  - LOW_LEVEL ≤ water_level ≤ HIGH_LEVEL.
- hold=1 freezes all state, timers and the level, and forces both valves to 0; the FSM resumes exactly where it paused. Request and boat pulses are still latched during hold.
- boat_in/boat_out outside their wait states are ignored.
- Reset mid-operation returns everything to the reset values on the next edge, regardless of level or gate position.

Test Plan:
- Reset, then arrive_low, then boat_in at cycle 5:
  - CLOSE lasts 3 cycles, then FILL.
  - Level goes 8 to 40 in 8 ticks (40 cycles).
  - OPEN lasts 3 cycles, then upper_gate_open=1 and state EXIT.
  - boat_out gives occupied=0 and state_code=2.
- From HIGH_IDLE with the chamber empty, arrive_low:
  - Turnaround: DRAIN 40 to 8 in 40 cycles.
  - Lower gate opens; state LOW_IDLE then LOW_ENTER.
  - pend_low stays set until boat_in.
- arrive_low and arrive_high on the same cycle in LOW_IDLE:
  - The lower boat is served first; pend_high stays 1 throughout.
  - After EXIT the FSM is in HIGH_IDLE and enters HIGH_ENTER.
- hold=1 for 10 cycles mid-FILL at level 24:
  - fill_valve=0 and level stays 24 throughout.
  - Tick phase is preserved; total fill time grows by exactly 10.
- reset asserted mid-DRAIN at level 20: next cycle level=8, lower_gate_open=1, pend flags 0, state_code=0.
- Throughout all scenarios, the invariant assertions never fire, including boat_in pulses sent during FILL, which must be ignored.

Source files
------------

// File: rtl/lock_chamber_if.sv
// Boat/request/hold inputs and gate/valve/status outputs of the lock chamber sequencer.
interface lock_chamber_if #(
    parameter int unsigned LEVEL_W = 6
) ();
    logic               arrive_low;
    logic               arrive_high;
    logic               boat_in;
    logic               boat_out;
    logic               hold;
    logic               lower_gate_open;
    logic               upper_gate_open;
    logic               gate_moving;
    logic               fill_valve;
    logic               drain_valve;
    logic               occupied;
    logic [LEVEL_W-1:0] water_level;
    logic               pend_low;
    logic               pend_high;
    logic [3:0]         state_code;

    // Environment side: drives requests and boat events, observes the chamber.
    modport master (
        output arrive_low, arrive_high, boat_in, boat_out, hold,
        input  lower_gate_open, upper_gate_open, gate_moving, fill_valve, drain_valve,
        input  occupied, water_level, pend_low, pend_high, state_code
    );

    // Controller side.
    modport slave (
        input  arrive_low, arrive_high, boat_in, boat_out, hold,
        output lower_gate_open, upper_gate_open, gate_moving, fill_valve, drain_valve,
        output occupied, water_level, pend_low, pend_high, state_code
    );
endinterface

// File: rtl/lock_chamber_ctrl.sv
// Single-chamber canal-lock sequencer: request latching, gate travel timing,
// water level tracking with fill/drain valves, and a hold input that freezes everything.
module lock_chamber_ctrl #(
    parameter int unsigned LEVEL_W     = 6,
    parameter int unsigned LOW_LEVEL   = 8,
    parameter int unsigned HIGH_LEVEL  = 40,
    parameter int unsigned FILL_STEP   = 4,
    parameter int unsigned DRAIN_STEP  = 4,
    parameter int unsigned TICK_DIV    = 5,
    parameter int unsigned GATE_CYCLES = 3
) (
    input  logic          clk,
    input  logic          reset,
    lock_chamber_if.slave bus
);
    typedef enum logic [3:0] {
        StLowIdle   = 4'd0,
        StLowEnter  = 4'd1,
        StHighIdle  = 4'd2,
        StHighEnter = 4'd3,
        StClose     = 4'd4,
        StFill      = 4'd5,
        StDrain     = 4'd6,
        StOpen      = 4'd7,
        StExit      = 4'd8
    } state_e;

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TickW-1:0]   TickLast = TickW'(TICK_DIV - 1);
    localparam logic [GateW-1:0]   GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LowLvl   = LEVEL_W'(LOW_LEVEL);
    localparam logic [LEVEL_W-1:0] HighLvl  = LEVEL_W'(HIGH_LEVEL);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [GateW-1:0]   gate_q, gate_d;
    logic               dir_up_q, dir_up_d;
    logic               occupied_q, occupied_d;
    logic               pend_low_q, pend_low_d;
    logic               pend_high_q, pend_high_d;
    logic               lower_open_q, lower_open_d;
    logic               upper_open_q, upper_open_d;
    logic               in_seen_q, in_seen_d;
    logic               out_seen_q, out_seen_d;
    logic               clr_low, clr_high;
    logic               boat_in_ev, boat_out_ev;
    logic               fill_on, drain_on;
    logic [LEVEL_W:0]   fill_sum;

    // Boat pulses landing during hold are remembered so the step fires on resume.
    assign boat_in_ev  = (bus.boat_in || in_seen_q) &&
                         (state_q == StLowEnter || state_q == StHighEnter);
    assign boat_out_ev = (bus.boat_out || out_seen_q) && (state_q == StExit);
    assign fill_sum    = {1'b0, level_q} + (LEVEL_W + 1)'(FILL_STEP);

    // Next-state, timers, level and gate decisions; nothing moves while hold is high.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        tick_d       = tick_q;
        gate_d       = gate_q;
        dir_up_d     = dir_up_q;
        occupied_d   = occupied_q;
        lower_open_d = lower_open_q;
        upper_open_d = upper_open_q;
        clr_low      = 1'b0;
        clr_high     = 1'b0;
        in_seen_d    = bus.hold && boat_in_ev;
        out_seen_d   = bus.hold && boat_out_ev;
        if (!bus.hold) begin
            unique case (state_q)
                StLowIdle: begin
                    if (pend_low_q) begin
                        state_d = StLowEnter;
                    end else if (pend_high_q) begin
                        dir_up_d     = 1'b1;
                        state_d      = StClose;
                        gate_d       = '0;
                        lower_open_d = 1'b0;
                        upper_open_d = 1'b0;
                    end
                end
                StHighIdle: begin
                    if (pend_high_q) begin
                        state_d = StHighEnter;
                    end else if (pend_low_q) begin
                        dir_up_d     = 1'b0;
                        state_d      = StClose;
                        gate_d       = '0;
                        lower_open_d = 1'b0;
                        upper_open_d = 1'b0;
                    end
                end
                StLowEnter, StHighEnter: begin
                    if (boat_in_ev) begin
                        occupied_d   = 1'b1;
                        clr_low      = (state_q == StLowEnter);
                        clr_high     = (state_q == StHighEnter);
                        dir_up_d     = (state_q == StLowEnter);
                        state_d      = StClose;
                        gate_d       = '0;
                        lower_open_d = 1'b0;
                        upper_open_d = 1'b0;
                    end
                end
                StClose: begin
                    if (gate_q == GateLast) begin
                        state_d = dir_up_q ? StFill : StDrain;
                        tick_d  = '0;
                    end else begin
                        gate_d = gate_q + GateW'(1);
                    end
                end
                StFill: begin
                    if (level_q == HighLvl) begin
                        state_d = StOpen;
                        gate_d  = '0;
                    end else if (tick_q == TickLast) begin
                        tick_d  = '0;
                        level_d = (fill_sum >= (LEVEL_W + 1)'(HIGH_LEVEL)) ? HighLvl
                                                                            : fill_sum[LEVEL_W-1:0];
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                StDrain: begin
                    if (level_q == LowLvl) begin
                        state_d = StOpen;
                        gate_d  = '0;
                    end else if (tick_q == TickLast) begin
                        tick_d = '0;
                        if ({1'b0, level_q} <= (LEVEL_W + 1)'(LOW_LEVEL + DRAIN_STEP)) begin
                            level_d = LowLvl;
                        end else begin
                            level_d = level_q - LEVEL_W'(DRAIN_STEP);
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                StOpen: begin
                    if (gate_q == GateLast) begin
                        upper_open_d = dir_up_q;
                        lower_open_d = !dir_up_q;
                        if (occupied_q) begin
                            state_d = StExit;
                        end else begin
                            state_d = dir_up_q ? StHighIdle : StLowIdle;
                        end
                    end else begin
                        gate_d = gate_q + GateW'(1);
                    end
                end
                StExit: begin
                    if (boat_out_ev) begin
                        occupied_d = 1'b0;
                        state_d    = upper_open_q ? StHighIdle : StLowIdle;
                    end
                end
                default: state_d = StLowIdle;
            endcase
        end
        // A repeat arrival while pending is absorbed; serving clears the flag.
        pend_low_d  = (pend_low_q  || bus.arrive_low)  && !clr_low;
        pend_high_d = (pend_high_q || bus.arrive_high) && !clr_high;
    end

    // State register with synchronous reset back to an empty chamber at the low level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StLowIdle;
            level_q      <= LowLvl;
            tick_q       <= '0;
            gate_q       <= '0;
            dir_up_q     <= 1'b0;
            occupied_q   <= 1'b0;
            pend_low_q   <= 1'b0;
            pend_high_q  <= 1'b0;
            lower_open_q <= 1'b1;
            upper_open_q <= 1'b0;
            in_seen_q    <= 1'b0;
            out_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            tick_q       <= tick_d;
            gate_q       <= gate_d;
            dir_up_q     <= dir_up_d;
            occupied_q   <= occupied_d;
            pend_low_q   <= pend_low_d;
            pend_high_q  <= pend_high_d;
            lower_open_q <= lower_open_d;
            upper_open_q <= upper_open_d;
            in_seen_q    <= in_seen_d;
            out_seen_q   <= out_seen_d;
        end
    end

    assign fill_on  = (state_q == StFill)  && !bus.hold;
    assign drain_on = (state_q == StDrain) && !bus.hold;

    assign bus.lower_gate_open = lower_open_q;
    assign bus.upper_gate_open = upper_open_q;
    assign bus.gate_moving     = (state_q == StClose) || (state_q == StOpen);
    assign bus.fill_valve      = fill_on;
    assign bus.drain_valve     = drain_on;
    assign bus.occupied        = occupied_q;
    assign bus.water_level     = level_q;
    assign bus.pend_low        = pend_low_q;
    assign bus.pend_high       = pend_high_q;
    assign bus.state_code      = state_q;

    a_one_gate: assert property (@(posedge clk) disable iff (reset)
        !(lower_open_q && upper_open_q));
    a_valve_sealed: assert property (@(posedge clk) disable iff (reset)
        (fill_on || drain_on) |-> !(lower_open_q || upper_open_q));
    a_valve_excl: assert property (@(posedge clk) disable iff (reset)
        !(fill_on && drain_on));
    a_level_range: assert property (@(posedge clk) disable iff (reset)
        (level_q >= LowLvl) && (level_q <= HighLvl));
endmodule
